regmap_access_arbiter: RTL and testbench

Shares the single write/read port of the configuration/status register map between two requesters: requester 0 is the host serial interface and requester 1 is the on-chip sequencer. The block also sequences each access to meet the register map's port timing. Writes are driven as a stable address/data window, with a held write-enable level sized for the register map's write-enable synchronizer. Reads hold read-enable through the register map's two-stage read pipeline. Illegal accesses are answered locally, without touching the register map.

---
 rtl/regmap_access_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_regmap_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regmap_access_arbiter.sv
// Two-requester arbiter and access sequencer for the register map port.
// Define REGMAP_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module regmap_access_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CONFIG_REG = 12,
  parameter int NUM_STATUS_REG = 4,
  parameter int WR_HOLD        = 4,
  parameter int WR_GAP         = 4,
  parameter int RD_CYCLES      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic                  req0_we_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  output logic                  rsp0_valid_o,
  output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
  output logic                  rsp0_err_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic                  req1_we_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  output logic                  rsp1_valid_o,
  output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
  output logic                  rsp1_err_o,
  output logic [ADDR_WIDTH-1:0] rm_addr_o,
  output logic [DATA_WIDTH-1:0] rm_write_data_o,
  output logic                  rm_write_en_o,
  output logic                  rm_read_en_o,
  input  logic [DATA_WIDTH-1:0] rm_read_data_i
);

  localparam int CNT_MAX_A = (WR_HOLD > WR_GAP) ? WR_HOLD : WR_GAP;
  localparam int CNT_MAX   = (CNT_MAX_A > RD_CYCLES) ? CNT_MAX_A : RD_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(WR_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(WR_GAP - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_CYCLES - 1);

  localparam logic [ADDR_WIDTH:0] CFG_LIM = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG);
  localparam logic [ADDR_WIDTH:0] ALL_LIM = (ADDR_WIDTH + 1)'(NUM_CONFIG_REG + NUM_STATUS_REG);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_HOLD,
    ST_WR_GAP,
    ST_RD_EN,
    ST_RD_CAP,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    id_q, id_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   rm_addr_q, rm_addr_d;
  logic [DATA_WIDTH-1:0]   rm_wdata_q, rm_wdata_d;
  logic                    rm_we_q, rm_we_d;
  logic                    rm_re_q, rm_re_d;

  logic                    grant;
  logic                    accept;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_illegal;

`ifdef REGMAP_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = ~req0_valid_i;
  end
`else
  logic last_q, last_d;

  // On contention the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    if (req0_valid_i && req1_valid_i) grant = ~last_q;
    else                              grant = req1_valid_i;
  end

  always_comb begin
    last_d = last_q;
    if (accept) last_d = grant;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // Handshake: a request is taken on the edge where its valid and ready are both high;
  // ready is only offered in IDLE, to the granted requester, while that requester is valid.
  assign req0_ready_o = rst_n && (state_q == ST_IDLE) && req0_valid_i && !grant;
  assign req1_ready_o = rst_n && (state_q == ST_IDLE) && req1_valid_i &&  grant;
  assign accept       = req0_ready_o || req1_ready_o;

  assign sel_we      = grant ? req1_we_i    : req0_we_i;
  assign sel_addr    = grant ? req1_addr_i  : req0_addr_i;
  assign sel_wdata   = grant ? req1_wdata_i : req0_wdata_i;
  assign sel_illegal = sel_we ? ({1'b0, sel_addr} >= CFG_LIM)
                              : ({1'b0, sel_addr} >= ALL_LIM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rm_addr_d  = rm_addr_q;
    rm_wdata_d = rm_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d  = grant;
          cnt_d = '0;
          if (sel_illegal) begin
            // Answered locally; the register map port is left untouched.
            err_d   = 1'b1;
            rdata_d = sel_we ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
            state_d = ST_RESP;
          end else begin
            err_d      = 1'b0;
            rdata_d    = '0;
            rm_addr_d  = sel_addr;
            rm_wdata_d = sel_wdata;
            state_d    = sel_we ? ST_WR_SETUP : ST_RD_EN;
          end
        end
      end
      ST_WR_SETUP: begin
        cnt_d   = '0;
        state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = ST_WR_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_EN: begin
        if (cnt_q == RD_LAST) begin
          cnt_d   = '0;
          state_d = ST_RD_CAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RD_CAP: begin
        rdata_d = rm_read_data_i;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Enables are registered off the next state so they are glitch-free at the register map.
  assign rm_we_d = (state_d == ST_WR_HOLD);
  assign rm_re_d = (state_d == ST_RD_EN);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rm_addr_q  <= '0;
      rm_wdata_q <= '0;
      rm_we_q    <= 1'b0;
      rm_re_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rm_addr_q  <= rm_addr_d;
      rm_wdata_q <= rm_wdata_d;
      rm_we_q    <= rm_we_d;
      rm_re_q    <= rm_re_d;
    end
  end

  assign rm_addr_o       = rm_addr_q;
  assign rm_write_data_o = rm_wdata_q;
  assign rm_write_en_o   = rm_we_q;
  assign rm_read_en_o    = rm_re_q;

  assign rsp0_valid_o = (state_q == ST_RESP) && !id_q;
  assign rsp1_valid_o = (state_q == ST_RESP) &&  id_q;
  assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : '0;
  assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : '0;
  assign rsp0_err_o   = rsp0_valid_o && err_q;
  assign rsp1_err_o   = rsp1_valid_o && err_q;

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// Bench for regmap_access_arbiter: directed and random requests checked against a
// window/latency model of each access. Honours REGMAP_ARB_FIXED_PRIO_EN.
module tb_regmap_access_arbiter;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int NCFG  = 12;
  localparam int NSTAT = 4;
  localparam int WRH   = 4;
  localparam int WRG   = 4;
  localparam int RDC   = 2;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid_i, req0_ready_o, req0_we_i;
  logic [AW-1:0] req0_addr_i;
  logic [DW-1:0] req0_wdata_i;
  logic          rsp0_valid_o, rsp0_err_o;
  logic [DW-1:0] rsp0_rdata_o;
  logic          req1_valid_i, req1_ready_o, req1_we_i;
  logic [AW-1:0] req1_addr_i;
  logic [DW-1:0] req1_wdata_i;
  logic          rsp1_valid_o, rsp1_err_o;
  logic [DW-1:0] rsp1_rdata_o;
  logic [AW-1:0] rm_addr_o;
  logic [DW-1:0] rm_write_data_o, rm_read_data_i;
  logic          rm_write_en_o, rm_read_en_o;

  regmap_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONFIG_REG(NCFG), .NUM_STATUS_REG(NSTAT),
    .WR_HOLD(WRH), .WR_GAP(WRG), .RD_CYCLES(RDC)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_we_i(req0_we_i),
    .req0_addr_i(req0_addr_i), .req0_wdata_i(req0_wdata_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_we_i(req1_we_i),
    .req1_addr_i(req1_addr_i), .req1_wdata_i(req1_wdata_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
    .rm_addr_o(rm_addr_o), .rm_write_data_o(rm_write_data_o),
    .rm_write_en_o(rm_write_en_o), .rm_read_en_o(rm_read_en_o),
    .rm_read_data_i(rm_read_data_i)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [7:0] init_val(input int i);
    case (i)
      12:      return 8'hA1;
      13:      return 8'h77;
      14:      return 8'h3C;
      15:      return 8'hC5;
      default: return 8'(i * 29 + 7);
    endcase
  endfunction

  // ---------------- register map environment ----------------
  logic [7:0] regfile [0:15];
  logic       load_env = 1'b0;
  assign rm_read_data_i = (rm_addr_o < 7'd16) ? regfile[rm_addr_o[3:0]] : 8'h00;

  initial begin : env
    forever begin
      @(posedge clk_i);
      if (load_env) begin
        for (int i = 0; i < 16; i++) regfile[i] <= init_val(i);
      end else if (rm_write_en_o && rm_addr_o < 7'd16) begin
        regfile[rm_addr_o[3:0]] <= rm_write_data_o;
      end
    end
  end

  // ---------------- request queues and driver ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t q0 [0:255];
  req_t q1 [0:255];
  int   wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic acc0 = 1'b0, acc1 = 1'b0;

  task automatic push(input int n, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd);
    if (n == 0) begin q0[wr0] = {we, addr, wd}; wr0++; end
    else        begin q1[wr1] = {we, addr, wd}; wr1++; end
  endtask

  initial begin : driver
    req0_valid_i = 1'b0; req0_we_i = 1'b0; req0_addr_i = '0; req0_wdata_i = '0;
    req1_valid_i = 1'b0; req1_we_i = 1'b0; req1_addr_i = '0; req1_wdata_i = '0;
    forever begin
      @(posedge clk_i);
      #2;
      if (acc0) rd0++;
      if (acc1) rd1++;
      if (rd0 != wr0) begin
        req0_valid_i = 1'b1;
        {req0_we_i, req0_addr_i, req0_wdata_i} = q0[rd0];
      end else begin
        req0_valid_i = 1'b0;
      end
      if (rd1 != wr1) begin
        req1_valid_i = 1'b1;
        {req1_we_i, req1_addr_i, req1_wdata_i} = q1[rd1];
      end else begin
        req1_valid_i = 1'b0;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // One access is in flight at a time; each is described by its accept cycle and the
  // cycle offsets at which the enables, the address window and the response must appear.
  logic          mon_en = 1'b0;
  logic          have_rec = 1'b0;
  int            rec_t, rec_lat, rec_end;
  logic          rec_id, rec_we, rec_bad;
  logic [AW-1:0] rec_addr;
  logic [DW-1:0] rec_wdata;
  logic [DW-1:0] exp_q [$];
  logic          grants_q [$];
  logic          last = 1'b1;
  logic [7:0]    ref_mem [0:15];

  initial begin : monitor
    int   c, d;
    logic e_we, e_re, e_r0, e_r1, idle, win, v0, v1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        c = cyc;
        e_we = 1'b0; e_re = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
        if (have_rec && c > rec_t && c <= rec_end) begin
          d = c - rec_t;
          if (!rec_bad) begin
            e_we = rec_we && d >= 2 && d <= 1 + WRH;
            e_re = !rec_we && d <= RDC;
            check("rm_addr", rm_addr_o, rec_addr);
            if (rec_we) check("rm_wdata", rm_write_data_o, rec_wdata);
          end
          if (d == rec_lat) begin
            e_r0 = !rec_id;
            e_r1 = rec_id;
            if (exp_q.size() > 0) begin
              check("rsp_rdata", rec_id ? rsp1_rdata_o : rsp0_rdata_o, exp_q.pop_front());
              check("rsp_err", rec_id ? rsp1_err_o : rsp0_err_o, rec_bad);
            end
          end
        end
        check("rm_write_en", rm_write_en_o, e_we);
        check("rm_read_en", rm_read_en_o, e_re);
        check("rsp0_valid", rsp0_valid_o, e_r0);
        check("rsp1_valid", rsp1_valid_o, e_r1);
        if (!rst_n) begin
          // Interrupted access: nothing of it is expected after this edge.
          if (have_rec && rec_end > c) begin
            rec_end = c;
            exp_q.delete();
          end
          last = 1'b1;
          acc0 = 1'b0;
          acc1 = 1'b0;
        end else begin
          idle = !have_rec || c > rec_end;
          v0 = req0_valid_i;
          v1 = req1_valid_i;
`ifdef REGMAP_ARB_FIXED_PRIO_EN
          win = !v0;
`else
          win = (v0 && v1) ? !last : v1;
`endif
          check("req0_ready", req0_ready_o, idle && v0 && !win);
          check("req1_ready", req1_ready_o, idle && v1 && win);
          if (idle && (v0 || v1)) begin
            have_rec  = 1'b1;
            rec_t     = c;
            rec_id    = win;
            rec_we    = win ? req1_we_i : req0_we_i;
            rec_addr  = win ? req1_addr_i : req0_addr_i;
            rec_wdata = win ? req1_wdata_i : req0_wdata_i;
            rec_bad   = rec_we ? (rec_addr >= 7'(NCFG)) : (rec_addr >= 7'(NCFG + NSTAT));
            rec_lat   = rec_bad ? 1 : (rec_we ? 2 + WRH + WRG : RDC + 2);
            rec_end   = c + rec_lat;
            exp_q.delete();
            if (rec_bad)     exp_q.push_back(rec_we ? 8'h00 : 8'hFF);
            else if (rec_we) exp_q.push_back(8'h00);
            else             exp_q.push_back(ref_mem[rec_addr[3:0]]);
            if (!rec_bad && rec_we) ref_mem[rec_addr[3:0]] = rec_wdata;
            last = win;
            grants_q.push_back(win);
          end
          acc0 = req0_valid_i && req0_ready_o;
          acc1 = req1_valid_i && req1_ready_o;
        end
      end
    end
  end

  task automatic wait_drain(input int max_cyc);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(posedge clk_i);
      #3;
      if (rd0 == wr0 && rd1 == wr1 && (!have_rec || cyc > rec_end)) done = 1'b1;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_pulse();
    @(posedge clk_i);
    #1 rst_n = 1'b0;
    @(posedge clk_i);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int   base;
    logic hit;
    logic exp_g [4];
    repeat (2) @(posedge clk_i);
    #1 load_env = 1'b1;
    @(posedge clk_i);
    #1 load_env = 1'b0;
    @(negedge clk_i);
    check("rst_req0_ready", req0_ready_o, 0);
    check("rst_req1_ready", req1_ready_o, 0);
    check("rst_rsp0_valid", rsp0_valid_o, 0);
    check("rst_rsp1_valid", rsp1_valid_o, 0);
    check("rst_rsp0_rdata", rsp0_rdata_o, 0);
    check("rst_rsp1_rdata", rsp1_rdata_o, 0);
    check("rst_rsp0_err", rsp0_err_o, 0);
    check("rst_rsp1_err", rsp1_err_o, 0);
    check("rst_rm_addr", rm_addr_o, 0);
    check("rst_rm_wdata", rm_write_data_o, 0);
    check("rst_rm_we", rm_write_en_o, 0);
    check("rst_rm_re", rm_read_en_o, 0);
    @(posedge clk_i);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Write then read back, status read, illegal write and illegal read.
    push(0, 1'b1, 7'd3, 8'h5A);  wait_drain(100);
    push(0, 1'b0, 7'd3, 8'h00);  wait_drain(100);
    push(1, 1'b0, 7'd13, 8'h00); wait_drain(100);
    push(0, 1'b1, 7'd12, 8'h33); wait_drain(100);
    push(0, 1'b0, 7'd16, 8'h00); wait_drain(100);

    // Contention: both sides hold four requests from the same cycle.
    reset_pulse();
    base = grants_q.size();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b0, 7'($urandom_range(0, 15)), 8'h00);
      push(1, 1'b0, 7'($urandom_range(0, 15)), 8'h00);
    end
    wait_drain(300);
`ifdef REGMAP_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    if (grants_q.size() < base + 4) check("grant_count", grants_q.size() - base, 4);
    else for (int i = 0; i < 4; i++) check("grant_seq", grants_q[base + i], exp_g[i]);

    // Reset in cycle 3 of a write; data equals current contents so landing is harmless.
    push(0, 1'b1, 7'd5, ref_mem[5]);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk_i);
      #1;
      if (have_rec && rec_we && cyc == rec_t + 3) hit = 1'b1;
    end
    if (!hit) begin
      check("rst_window", 32'd0, 32'd1);
    end else begin
      rst_n = 1'b0;
      @(posedge clk_i);
      #1 rst_n = 1'b1;
      @(negedge clk_i);
      check("midrst_write_en", rm_write_en_o, 0);
      check("midrst_rsp0", rsp0_valid_o, 0);
    end
    push(0, 1'b0, 7'd5, 8'h00);
    wait_drain(100);

    // Random mix from both requesters, including out-of-range addresses.
    for (int i = 0; i < 60; i++) begin
      push($urandom_range(0, 1), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 17)),
           8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
    end
    wait_drain(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    check("watchdog", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
